hs_rr_arbiter: RTL and testbench
================================

// Module: hs_rr_arbiter
// PURPOSE
//  N-input round-robin arbiter that shares one valid/ready output channel
//  between N valid/ready requesters. Grants are packet-locked via per-input
//  last flags. One registered output stage: 1-cycle latency, full throughput.
//  Sits between producer handshake stages and a single downstream consumer.
// PARAMETERS
//  N    4   number of requesters (2..16)
//  DW   8   data width per beat
//  IW   2   id width, = $clog2(N)
// PORTS
//  clk          in   1     clock, all logic on rising edge
//  rst_n        in   1     async active-low reset
//  req_valid_i  in   N     per-requester valid
//  req_last_i   in   N     per-requester last-beat-of-packet flag
//  req_data_i   in   N*DW  packed data; requester i at [i*DW +: DW]
//  req_ready_o  out  N     per-requester ready (combinational, one-hot or 0)
//  out_valid_o  out  1     output beat valid (registered)
//  out_last_o   out  1     output beat is last of packet (registered)
//  out_data_o   out  DW    output data (registered)
//  out_id_o     out  IW    index of requester owning the output beat
//  out_ready_i  in   1     downstream ready
//  busy_o       out  1     1 while FSM in LOCK
// BEHAVIOUR
//  Reset: out_valid_o=0, out_last_o=0, out_data_o=0, out_id_o=0, busy_o=0,
//   state=ARB, rr pointer ptr=0; req_ready_o forced 0 while rst_n low.
//  load_en = ~out_valid_o | out_ready_i (output register empty or draining).
//  Beat i accepted on a cycle iff req_valid_i[i] & req_ready_o[i]; accepted
//   beat appears on out_* the next cycle with out_valid_o=1.
//  out_valid_o clears when out_ready_i=1 and no new beat is loaded.
//  Output held stable (data/last/id) while out_valid_o & ~out_ready_i.
//  FSM ARB: winner = first i with req_valid_i[i] scanning ptr, ptr+1, ...
//   wrapping at N-1 -> 0. If load_en and winner exists: req_ready_o[winner]=1.
//   On accept: last=1 -> stay ARB, ptr<=winner+1 (mod N);
//   last=0 -> LOCK, owner<=winner.
//  FSM LOCK: only owner eligible; req_ready_o[owner]=load_en. Other
//   requesters' valids ignored (held off). On owner accept with last=1 ->
//   ARB, ptr<=owner+1 (mod N). Owner dropping valid mid-packet keeps LOCK.
//  ptr only advances at packet end; single-beat packets rotate every beat.
//  req_ready_o never depends on req_valid_i of non-winners; at most one bit set.
//  Simultaneous drain and load: out_ready_i=1 with a new accept -> out_*
//   replaced by new beat, out_valid_o stays 1, no bubble.
//  No requester valid in ARB: req_ready_o=0, ptr unchanged.
//  Requester data/last must be stable while valid & ~ready (upstream rule).
//  Async reset mid-packet: lock dropped, held output beat discarded,
//   all state to reset values.
//  N not power of 2: pointer wrap uses explicit compare, never plain overflow.
// TESTING
//  1. Reset: rst_n=0 with all valids=1 -> req_ready_o=0, out_valid_o=0;
//     release -> first beat from req 0, out_id_o=0 one cycle later.
//  2. All 4 valid, last=1 always, out_ready_i=1 -> out_id_o 0,1,2,3,0,...
//     one beat per cycle, no bubbles.
//  3. Req1 sends 3-beat packet (last on beat 3), req2 valid throughout ->
//     ids 1,1,1 then 2; busy_o=1 during beats 1-2; req_ready_o[2]=0 till then.
//  4. out_ready_i=0 for 5 cycles with beat 0xA5 held -> out_data_o=0xA5
//     stable, all req_ready_o=0; ready back -> next beat following cycle.
//  5. Owner req3 drops valid mid-packet for 3 cycles while req0 valid ->
//     no grant to req0; packet resumes from req3 and ends, then req0 granted.
//  6. rst_n pulsed low mid-packet (out_valid_o=1) -> outputs zero
//     immediately; after release arbitration restarts at ptr=0.

Source files
------------

// File: rtl/hs_rr_arbiter.sv
// N-way round-robin valid/ready arbiter with per-packet grant locking and a
// single registered output stage (1-cycle latency, full throughput).
module hs_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid_i,
  input  logic [N-1:0]    req_last_i,
  input  logic [N*DW-1:0] req_data_i,
  output logic [N-1:0]    req_ready_o,
  output logic            out_valid_o,
  output logic            out_last_o,
  output logic [DW-1:0]   out_data_o,
  output logic [IW-1:0]   out_id_o,
  input  logic            out_ready_i,
  output logic            busy_o
);

  localparam logic [0:0]    ST_ARB   = 1'b0;
  localparam logic [0:0]    ST_LOCK  = 1'b1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [0:0]    r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_owner;
  logic          r_out_valid;
  logic          r_out_last;
  logic [DW-1:0] r_out_data;
  logic [IW-1:0] r_out_id;

  logic          w_load_en;
  logic          w_found;
  logic          w_sel_ok;
  logic          w_accept;
  logic          w_acc_last;
  logic [IW-1:0] w_winner;
  logic [IW-1:0] w_sel;
  logic [DW-1:0] w_acc_data;
  logic [N-1:0]  w_ready;
  logic [DW-1:0] w_req_data [N];

  // Explicit wrap so non-power-of-two N never relies on counter overflow.
  function automatic logic [IW-1:0] f_wrap_inc(input logic [IW-1:0] v);
    return (v == LAST_IDX) ? '0 : v + IW'(1);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_req_data[gi] = req_data_i[gi*DW +: DW];
    end
  endgenerate

  always_comb begin : p_scan
    logic [IW-1:0] cand;
    w_found  = 1'b0;
    w_winner = r_ptr;
    cand     = r_ptr;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req_valid_i[cand]) begin
        w_found  = 1'b1;
        w_winner = cand;
      end
      cand = f_wrap_inc(cand);
    end
  end

  assign w_load_en = ~r_out_valid | out_ready_i;
  assign w_sel     = (r_state == ST_LOCK) ? r_owner : w_winner;
  // A locked owner is offered ready even while its valid is low.
  assign w_sel_ok  = (r_state == ST_LOCK) | w_found;

  always_comb begin
    w_ready = '0;
    if (rst_n && w_load_en && w_sel_ok) w_ready[w_sel] = 1'b1;
  end

  assign w_accept   = |(req_valid_i & w_ready);
  assign w_acc_last = req_last_i[w_sel];
  assign w_acc_data = w_req_data[w_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ARB;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_last  <= w_acc_last;
        r_out_data  <= w_acc_data;
        r_out_id    <= w_sel;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_ARB: begin
          if (w_accept) begin
            if (w_acc_last) begin
              r_ptr <= f_wrap_inc(w_sel);
            end else begin
              r_state <= ST_LOCK;
              r_owner <= w_sel;
            end
          end
        end
        default: begin
          if (w_accept && w_acc_last) begin
            r_state <= ST_ARB;
            r_ptr   <= f_wrap_inc(r_owner);
          end
        end
      endcase
    end
  end

  assign req_ready_o = w_ready;
  assign out_valid_o = r_out_valid;
  assign out_last_o  = r_out_last;
  assign out_data_o  = r_out_data;
  assign out_id_o    = r_out_id;
  assign busy_o      = (r_state == ST_LOCK);

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed bench for hs_rr_arbiter: a packet-level scheduling model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_hs_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_last_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_ready_o;
  logic            out_valid_o;
  logic            out_last_o;
  logic [DW-1:0]   out_data_o;
  logic [IW-1:0]   out_id_o;
  logic            out_ready_i;
  logic            busy_o;

  int n_vec = 0;
  int n_err = 0;

  // Model: content of the output slot, round-robin start, packet owner (-1 = none)
  logic          m_valid = 1'b0;
  logic          m_last  = 1'b0;
  logic [DW-1:0] m_data  = '0;
  int            m_id    = 0;
  int            m_rr    = 0;
  int            m_owner = -1;
  logic [N-1:0]  seen_ready = '0;

  hs_rr_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_last_o  (out_last_o),
    .out_data_o  (out_data_o),
    .out_id_o    (out_id_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [DW-1:0] d);
    req_valid_i[i]         = v;
    req_last_i[i]          = l;
    req_data_i[i*DW +: DW] = d;
  endtask

  // Per-cycle compare against the model, then advance the model by one cycle.
  always @(negedge clk) begin : p_check
    logic [N-1:0] e_ready;
    logic         load;
    logic         found;
    int           acc;
    int           idx;
    if (!rst_n) begin
      chk("rst_ready", 32'(req_ready_o), 0);
      chk("rst_out", 32'({out_valid_o, out_last_o, busy_o, out_data_o, out_id_o}), 0);
      m_valid = 1'b0; m_last = 1'b0; m_data = '0; m_id = 0; m_rr = 0; m_owner = -1;
      seen_ready = '0;
    end else begin
      load    = !m_valid || out_ready_i;
      e_ready = '0;
      found   = 1'b0;
      if (load) begin
        if (m_owner >= 0) begin
          e_ready[m_owner] = 1'b1;
        end else begin
          for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (!found && req_valid_i[idx]) begin
              found        = 1'b1;
              e_ready[idx] = 1'b1;
            end
          end
        end
      end
      chk("ready", 32'(req_ready_o), 32'(e_ready));
      chk("out_valid", 32'(out_valid_o), 32'(m_valid));
      chk("out_last", 32'(out_last_o), 32'(m_last));
      chk("out_data", 32'(out_data_o), 32'(m_data));
      chk("out_id", 32'(out_id_o), 32'(m_id));
      chk("busy", 32'(busy_o), 32'(m_owner >= 0));
      if (out_valid_o && out_ready_i)
        $display("beat id=%0d data=%02h last=%0b", out_id_o, out_data_o, out_last_o);
      seen_ready = req_ready_o;

      acc = -1;
      for (int i = 0; i < N; i++)
        if (e_ready[i] && req_valid_i[i]) acc = i;
      if (acc >= 0) begin
        m_valid = 1'b1;
        m_last  = req_last_i[acc];
        m_data  = req_data_i[acc*DW +: DW];
        m_id    = acc;
        if (req_last_i[acc]) begin
          m_owner = -1;
          m_rr    = (acc + 1) % N;
        end else begin
          m_owner = acc;
        end
      end else if (out_ready_i) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    req_valid_i = '1;
    req_last_i  = '1;
    req_data_i  = '0;
    for (int i = 0; i < N; i++) req_data_i[i*DW +: DW] = DW'(8'h10 + i);
    out_ready_i = 1'b1;

    // Reset with every requester valid
    repeat (3) cyc();
    chk("t1_rst_ready", 32'(req_ready_o), 0);
    chk("t1_rst_valid", 32'(out_valid_o), 0);
    rst_n = 1'b1;
    #1;
    chk("t1_first_ready", 32'(req_ready_o), 32'h1);
    cyc();
    chk("t1_valid", 32'(out_valid_o), 1);
    chk("t1_id", 32'(out_id_o), 0);
    chk("t1_data", 32'(out_data_o), 32'h10);

    // Single-beat packets rotate every cycle with no bubble
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("t2_valid", 32'(out_valid_o), 1);
      chk("t2_id", 32'(out_id_o), 32'(k % 4));
      chk("t2_data", 32'(out_data_o), 32'(8'h10 + k % 4));
    end

    // Req1 three-beat packet locks out req2
    req_valid_i = '0;
    set_req(1, 1'b1, 1'b0, 8'hA1);
    set_req(2, 1'b1, 1'b1, 8'hB2);
    #1;
    chk("t3_ready_b1", 32'(req_ready_o), 32'h2);
    cyc();
    chk("t3_id_b1", 32'(out_id_o), 1);
    chk("t3_busy_b1", 32'(busy_o), 1);
    chk("t3_ready_lock", 32'(req_ready_o), 32'h2);
    set_req(1, 1'b1, 1'b0, 8'hA2);
    cyc();
    chk("t3_data_b2", 32'(out_data_o), 32'hA2);
    chk("t3_busy_b2", 32'(busy_o), 1);
    set_req(1, 1'b1, 1'b1, 8'hA3);
    cyc();
    chk("t3_data_b3", 32'(out_data_o), 32'hA3);
    chk("t3_busy_b3", 32'(busy_o), 0);
    chk("t3_ready_req2", 32'(req_ready_o), 32'h4);
    set_req(1, 1'b0, 1'b1, 8'h00);
    cyc();
    chk("t3_id_req2", 32'(out_id_o), 2);
    chk("t3_data_req2", 32'(out_data_o), 32'hB2);

    // Downstream stall holds 0xA5
    req_valid_i = '0;
    set_req(0, 1'b1, 1'b1, 8'hA5);
    cyc();
    chk("t4_data", 32'(out_data_o), 32'hA5);
    out_ready_i = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'h5A);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t4_hold_data", 32'(out_data_o), 32'hA5);
      chk("t4_hold_valid", 32'(out_valid_o), 1);
      chk("t4_hold_ready", 32'(req_ready_o), 0);
    end
    out_ready_i = 1'b1;
    #1;
    chk("t4_ready_back", 32'(req_ready_o), 32'h1);
    cyc();
    chk("t4_next_data", 32'(out_data_o), 32'h5A);
    req_valid_i = '0;

    // Owner req3 pauses mid-packet while req0 waits
    set_req(3, 1'b1, 1'b0, 8'h31);
    set_req(0, 1'b1, 1'b1, 8'h0C);
    cyc();
    chk("t5_id", 32'(out_id_o), 3);
    chk("t5_busy", 32'(busy_o), 1);
    req_valid_i[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t5_gap_ready", 32'(req_ready_o), 32'h8);
      chk("t5_gap_valid", 32'(out_valid_o), 0);
      chk("t5_gap_busy", 32'(busy_o), 1);
    end
    set_req(3, 1'b1, 1'b1, 8'h32);
    cyc();
    chk("t5_end_id", 32'(out_id_o), 3);
    chk("t5_end_data", 32'(out_data_o), 32'h32);
    chk("t5_end_busy", 32'(busy_o), 0);
    req_valid_i[3] = 1'b0;
    cyc();
    chk("t5_req0_id", 32'(out_id_o), 0);
    chk("t5_req0_data", 32'(out_data_o), 32'h0C);
    req_valid_i = '0;

    // Reset mid-packet with a held output beat
    set_req(2, 1'b1, 1'b0, 8'h66);
    cyc();
    chk("t6_busy", 32'(busy_o), 1);
    out_ready_i = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid_o), 0);
    chk("t6_rst_data", 32'(out_data_o), 0);
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_ready", 32'(req_ready_o), 0);
    cyc();
    cyc();
    req_valid_i = '0;
    req_last_i  = '1;
    set_req(0, 1'b1, 1'b1, 8'h77);
    set_req(3, 1'b1, 1'b1, 8'h33);
    out_ready_i = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("t6_ready_ptr0", 32'(req_ready_o), 32'h1);
    cyc();
    chk("t6_id", 32'(out_id_o), 0);
    chk("t6_data", 32'(out_data_o), 32'h77);

    // Mixed traffic and back-pressure, checked by the model only
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid_i[i] && !seen_ready[i]))
          set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, DW'($urandom));
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
      cyc();
    end

    req_valid_i = '0;
    out_ready_i = 1'b1;
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
